// File: rtl/keypad_matrix_scan_if.sv
// Pin-side bundle of the keypad scanner: matrix rows/columns plus the decoded key outputs.
// The master side is the scanner; the slave side is the board/watch core.
interface keypad_matrix_scan_if;
  logic [3:0] key_row;
  logic [2:0] key_col;
  logic [9:0] keypad;
  logic [3:0] key_code;
  logic       key_held;
  logic       key_valid;
  logic       key_release;

  modport master (
    input  key_row,
    output key_col, keypad, key_code, key_held, key_valid, key_release
  );

  modport slave (
    output key_row,
    input  key_col, keypad, key_code, key_held, key_valid, key_release
  );
endinterface

// File: rtl/keypad_matrix_scan.sv
// 4x3 keypad scanner: column-at-a-time scan, per-frame single-key decode,
// frame-based press/release debounce and held-key outputs.
module keypad_matrix_scan #(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  keypad_matrix_scan_if.master  kp
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {IDLE, PRESS_DB, PRESSED} state_t;

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [1:0]          col_idx_q, col_idx_d;
  logic [3:0]          row_s1_q, row_s2_q;
  logic [1:0]          acc_n_q, acc_n_d;
  logic [3:0]          acc_id_q, acc_id_d;
  logic [3:0]          cand_q, cand_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [9:0]          keypad_q, keypad_d;
  logic [3:0]          key_code_q, key_code_d;
  logic                key_held_q, key_held_d;
  logic                key_valid_q, key_valid_d;
  logic                key_release_q, key_release_d;

  logic [3:0]          col_hits;
  logic [2:0]          col_n, frame_tot;
  logic [1:0]          frame_n;
  logic [3:0]          col_id, frame_id;
  logic [CNT_W-1:0]    cnt_inc;
  logic                slot_end, frame_end, code_ok;

  function automatic logic [3:0] key_id(input logic [1:0] r, input logic [1:0] c);
    if (r != 2'd3) return {2'b00, r} * 4'd3 + {2'b00, c} + 4'd1;
    case (c)
      2'd0:    return 4'd10;
      2'd1:    return 4'd0;
      default: return 4'd11;
    endcase
  endfunction

  function automatic logic [9:0] digit_onehot(input logic [3:0] code);
    return (code < 4'd10) ? (10'd1 << code) : 10'd0;
  endfunction

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q + SLOT_W'(1);
    col_idx_d     = col_idx_q;
    acc_n_d       = acc_n_q;
    acc_id_d      = acc_id_q;
    cand_d        = cand_q;
    cnt_d         = cnt_q;
    keypad_d      = keypad_q;
    key_code_d    = key_code_q;
    key_held_d    = key_held_q;
    key_valid_d   = 1'b0;
    key_release_d = 1'b0;

    slot_end = (slot_q == SLOT_LAST);
    if (slot_end) begin
      slot_d    = '0;
      col_idx_d = (col_idx_q == 2'd2) ? 2'd0 : col_idx_q + 2'd1;
    end

    // Accumulate closed keys across the three column samples of a frame
    col_hits = ~row_s2_q;
    col_n    = 3'($countones(col_hits));
    col_id   = '0;
    for (int r = 3; r >= 0; r--) begin
      if (col_hits[r]) col_id = key_id(2'(r), col_idx_q);
    end
    frame_tot = ((col_idx_q == 2'd0) ? 3'd0 : {1'b0, acc_n_q}) + col_n;
    frame_n   = (frame_tot >= 3'd2) ? 2'd2 : frame_tot[1:0];
    frame_id  = (col_n != 3'd0) ? col_id : acc_id_q;
    if (slot_end) begin
      acc_n_d  = frame_n;
      acc_id_d = frame_id;
    end

    frame_end = slot_end && (col_idx_q == 2'd2);
    code_ok   = (frame_n == 2'd1);
    cnt_inc   = cnt_q + CNT_W'(1);

    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (code_ok) begin
            cand_d  = frame_id;
            cnt_d   = CNT_W'(1);
            state_d = PRESS_DB;
          end
        end
        PRESS_DB: begin
          if (!code_ok) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else if (frame_id == cand_q) begin
            if (cnt_inc == CNT_DONE) begin
              cnt_d       = '0;
              state_d     = PRESSED;
              keypad_d    = digit_onehot(cand_q);
              key_code_d  = cand_q;
              key_held_d  = 1'b1;
              key_valid_d = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cand_d = frame_id;
            cnt_d  = CNT_W'(1);
          end
        end
        PRESSED: begin
          // Anything but the held key (including another key) counts toward release
          if (code_ok && (frame_id == cand_q)) begin
            cnt_d = '0;
          end else if (cnt_inc == CNT_DONE) begin
            cnt_d         = '0;
            state_d       = IDLE;
            keypad_d      = '0;
            key_held_d    = 1'b0;
            key_release_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      slot_q        <= '0;
      col_idx_q     <= 2'd0;
      row_s1_q      <= 4'b1111;
      row_s2_q      <= 4'b1111;
      acc_n_q       <= 2'd0;
      acc_id_q      <= 4'd0;
      cand_q        <= 4'd0;
      cnt_q         <= '0;
      keypad_q      <= '0;
      key_code_q    <= 4'd0;
      key_held_q    <= 1'b0;
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      col_idx_q     <= col_idx_d;
      row_s1_q      <= kp.key_row;
      row_s2_q      <= row_s1_q;
      acc_n_q       <= acc_n_d;
      acc_id_q      <= acc_id_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      keypad_q      <= keypad_d;
      key_code_q    <= key_code_d;
      key_held_q    <= key_held_d;
      key_valid_q   <= key_valid_d;
      key_release_q <= key_release_d;
    end
  end

  assign kp.key_col     = ~(3'b001 << col_idx_q);
  assign kp.keypad      = keypad_q;
  assign kp.key_code    = key_code_q;
  assign kp.key_held    = key_held_q;
  assign kp.key_valid   = key_valid_q;
  assign kp.key_release = key_release_q;

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Bench for keypad_matrix_scan: a keypad matrix model drives the rows, and expected
// press/release events (code and cycle stamp) are queued and matched against output pulses.
module tb_keypad_matrix_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] pressed = '0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  bit          prev_v = 1'b0;
  bit          prev_r = 1'b0;

  typedef struct {
    bit         rel;
    logic [3:0] code;
    int         at;
  } ev_t;
  ev_t sb[$];

  keypad_matrix_scan_if kif ();

  keypad_matrix_scan #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(2)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  function automatic int row_of(input int k);
    if (k >= 1 && k <= 9) return (k - 1) / 3;
    return 3;
  endfunction

  function automatic int col_of(input int k);
    if (k >= 1 && k <= 9) return (k - 1) % 3;
    if (k == 0)  return 1;
    if (k == 10) return 0;
    return 2;
  endfunction

  function automatic logic [9:0] exp_kp(input logic [3:0] code);
    logic [9:0] v;
    v = '0;
    if (code <= 4'd9) v[code] = 1'b1;
    return v;
  endfunction

  // Matrix model: a pressed key pulls its row low while its column is driven low
  always_comb begin
    kif.key_row = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      if (pressed[k] && !kif.key_col[col_of(k)]) kif.key_row[row_of(k)] = 1'b0;
    end
  end

  task automatic tick();
    ev_t e;
    @(negedge clk);
    if (kif.key_valid || kif.key_release) begin
      total++;
      if ((kif.key_valid && prev_v) || (kif.key_release && prev_r)) begin
        bad++;
        $display("FAIL pulse_width: valid=%b release=%b prev_valid=%b prev_release=%b required single-clk pulse",
                 kif.key_valid, kif.key_release, prev_v, prev_r);
      end
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_event: valid=%b release=%b code=%0d at cyc=%0d, required no event",
                 kif.key_valid, kif.key_release, kif.key_code, cyc);
      end else begin
        e = sb.pop_front();
        total++;
        if ({kif.key_valid, kif.key_release} !== {!e.rel, e.rel}) begin
          bad++;
          $display("FAIL event_kind: got valid/release=%b%b, required %b%b",
                   kif.key_valid, kif.key_release, !e.rel, e.rel);
        end
        total++;
        if (cyc !== e.at) begin
          bad++;
          $display("FAIL event_time: got cyc=%0d, required cyc=%0d", cyc, e.at);
        end
        total++;
        if (kif.key_code !== e.code) begin
          bad++;
          $display("FAIL event_code: got %0d, required %0d", kif.key_code, e.code);
        end
        total++;
        if (kif.keypad !== (e.rel ? 10'd0 : exp_kp(e.code))) begin
          bad++;
          $display("FAIL event_keypad: got %b, required %b", kif.keypad, (e.rel ? 10'd0 : exp_kp(e.code)));
        end
        total++;
        if (kif.key_held !== !e.rel) begin
          bad++;
          $display("FAIL event_held: got %b, required %b", kif.key_held, !e.rel);
        end
      end
    end
    prev_v = kif.key_valid;
    prev_r = kif.key_release;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic align();
    while (cyc % 12 != 0) tick();
  endtask

  task automatic push_ev(input bit rel, input logic [3:0] code, input int at);
    ev_t e;
    e.rel = rel; e.code = code; e.at = at;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_missing: %0d expected event(s) not seen, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic press_key(input int id);
    int s;
    align();
    s = cyc;
    pressed = 12'(1) << id;
    push_ev(1'b0, 4'(id), s + 24);
    run(30);
    drain("press");
  endtask

  task automatic release_key(input int id);
    int s;
    align();
    s = cyc;
    pressed = '0;
    push_ev(1'b1, 4'(id), s + 24);
    run(30);
    drain("release");
  endtask

  task automatic check_reset_outputs(input string name);
    total++;
    if ({kif.key_col, kif.keypad, kif.key_code, kif.key_held, kif.key_valid, kif.key_release}
        !== {3'b110, 10'd0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL %s: col=%b keypad=%b code=%0d held=%b valid=%b release=%b, required col=110 others 0",
               name, kif.key_col, kif.keypad, kif.key_code, kif.key_held, kif.key_valid, kif.key_release);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    pressed = '0;
    run(3);
    check_reset_outputs("reset_state");
    rst = 1'b1;
  endtask

  task automatic test_hold_five();
    int s;
    align();
    s = cyc;
    pressed = 12'(1) << 5;
    push_ev(1'b0, 4'd5, s + 24);
    run(60);
    drain("hold5");
    total++;
    if (kif.keypad !== 10'b0000100000 || kif.key_held !== 1'b1 || kif.key_code !== 4'd5) begin
      bad++;
      $display("FAIL hold5_level: keypad=%b held=%b code=%0d, required 0000100000 1 5",
               kif.keypad, kif.key_held, kif.key_code);
    end
  endtask

  task automatic test_release_five();
    release_key(5);
    total++;
    if (kif.key_code !== 4'd5 || kif.key_held !== 1'b0 || kif.keypad !== 10'd0) begin
      bad++;
      $display("FAIL release5_level: code=%0d held=%b keypad=%b, required 5 0 0",
               kif.key_code, kif.key_held, kif.keypad);
    end
  endtask

  task automatic test_glitch();
    align();
    pressed = 12'(1) << 7;
    run(12);
    pressed = '0;
    for (int i = 0; i < 36; i++) begin
      tick();
      total++;
      if (kif.keypad !== 10'd0) begin
        bad++;
        $display("FAIL glitch_keypad: got %b, required 0", kif.keypad);
      end
    end
    // A full debounce right away shows the FSM went back to IDLE
    press_key(8);
    release_key(8);
  endtask

  task automatic test_multi_key();
    align();
    pressed = (12'(1) << 1) | (12'(1) << 2);
    for (int i = 0; i < 48; i++) begin
      tick();
      total++;
      if (kif.keypad !== 10'd0 || kif.key_held !== 1'b0) begin
        bad++;
        $display("FAIL multi_key: keypad=%b held=%b, required 0 0", kif.keypad, kif.key_held);
      end
    end
    pressed = '0;
    run(24);
  endtask

  task automatic test_star_hash();
    press_key(10);
    release_key(10);
    press_key(11);
    release_key(11);
  endtask

  task automatic test_back_to_back();
    int s;
    press_key(5);
    align();
    s = cyc;
    pressed = 12'(1) << 6;
    push_ev(1'b1, 4'd5, s + 24);
    push_ev(1'b0, 4'd6, s + 48);
    run(54);
    drain("back_to_back");
    release_key(6);
  endtask

  task automatic test_reset_mid_hold();
    press_key(3);
    run(5);
    rst = 1'b0;
    tick();
    check_reset_outputs("reset_mid_hold");
    rst = 1'b1;
    push_ev(1'b0, 4'd3, 24);
    run(30);
    drain("reaccept");
    release_key(3);
  endtask

  initial begin
    test_reset();
    test_hold_five();
    test_release_five();
    test_glitch();
    test_multi_key();
    test_star_hash();
    test_back_to_back();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
